// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch/decode/execute/memory/writeback
// and decodes Moore-style datapath controls, stalling on the memory ready handshake.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       PCEn,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal_op
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BEQ     = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t state_q, state_d, dec_state;
  logic   pc_write, branch;
  logic   mem_req_raw, mem_write_raw, ir_write_raw, reg_write_raw, done_raw, illegal_raw;

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:   if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BEQ;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   if (mem_ready) state_d = S_MEMWB;
      S_MEMWR:   if (mem_ready) state_d = S_FETCH;
      S_EXECUTE: state_d = S_ALUWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      default:   state_d = S_FETCH;
    endcase
  end

  // While in reset the selects look like FETCH; enables are gated off below.
  assign dec_state = reset_n ? state_q : S_FETCH;

  always_comb begin
    mem_req_raw   = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    done_raw      = 1'b0;
    illegal_raw   = 1'b0;
    pc_write      = 1'b0;
    branch        = 1'b0;
    IorD          = 1'b0;
    RegDst        = 1'b0;
    MemtoReg      = 1'b0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'b00;
    ALUOp         = 2'b00;
    PCSrc         = 2'b00;
    case (dec_state)
      S_FETCH: begin
        mem_req_raw  = 1'b1;
        ALUSrcB      = 2'b01;
        ir_write_raw = mem_ready;
        pc_write     = mem_ready;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        if (!(opcode inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J})) begin
          illegal_raw = 1'b1;
          done_raw    = 1'b1;
        end
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        mem_req_raw = 1'b1;
        IorD        = 1'b1;
      end
      S_MEMWB: begin
        reg_write_raw = 1'b1;
        MemtoReg      = 1'b1;
        done_raw      = 1'b1;
      end
      S_MEMWR: begin
        mem_req_raw   = 1'b1;
        IorD          = 1'b1;
        mem_write_raw = 1'b1;
        done_raw      = mem_ready;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_ALUWB: begin
        reg_write_raw = 1'b1;
        RegDst        = 1'b1;
        done_raw      = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA  = 1'b1;
        ALUOp    = 2'b01;
        branch   = 1'b1;
        PCSrc    = 2'b01;
        done_raw = 1'b1;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_ADDIWB: begin
        reg_write_raw = 1'b1;
        done_raw      = 1'b1;
      end
      S_JUMP: begin
        PCSrc    = 2'b10;
        pc_write = 1'b1;
        done_raw = 1'b1;
      end
      default: ALUSrcB = 2'b01;
    endcase
  end

  assign mem_req    = reset_n & mem_req_raw;
  assign MemWrite   = reset_n & mem_write_raw;
  assign IRWrite    = reset_n & ir_write_raw;
  assign RegWrite   = reset_n & reg_write_raw;
  assign PCEn       = reset_n & (pc_write | (branch & zero));
  assign instr_done = reset_n & done_raw;
  assign illegal_op = reset_n & illegal_raw;
  assign state      = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed literal sequences, then randomized
// traffic compared every cycle against an instruction-level state-path model.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset_n, zero, mem_ready;
  logic [5:0] opcode;
  logic       mem_req, IorD, MemWrite, IRWrite, RegWrite, PCEn, RegDst, MemtoReg, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
  logic [3:0] state;
  logic       instr_done, illegal_op;

  int errors = 0;
  int checks = 0;

  localparam logic [5:0] R = 6'h00, LW = 6'h23, SW = 6'h2b, BEQ = 6'h04, ADDI = 6'h08, J = 6'h02, ILL = 6'h3f;

  multicycle_controller dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .PCEn(PCEn), .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .PCSrc(PCSrc), .state(state), .instr_done(instr_done), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: each instruction expands into the list of states it visits after DECODE.
  int  mstate = 0;
  int  path[$];
  bit  chk_en = 1'b0;

  always @(posedge clk) begin
    if (!reset_n) begin
      mstate = 0;
      path.delete();
    end else if (!((mstate == 0 || mstate == 3 || mstate == 5) && !mem_ready)) begin
      if (mstate == 0) mstate = 1;
      else begin
        if (mstate == 1) begin
          case (opcode)
            R:       path = '{6, 7};
            LW:      path = '{2, 3, 4};
            SW:      path = '{2, 5};
            BEQ:     path = '{8};
            ADDI:    path = '{9, 10};
            J:       path = '{11};
            default: path.delete();
          endcase
        end
        if (path.size() > 0) mstate = path.pop_front();
        else                 mstate = 0;
      end
    end
    chk_en = 1'b1;
  end

  function automatic logic [16:0] expv(input int st, input logic mr, input logic z,
                                      input logic rn, input logic [5:0] op);
    logic mreq, iord, mw, irw, rw, pcen, rd, m2r, sa, done, ill;
    logic [1:0] sb, aop, pcs;
    {mreq, iord, mw, irw, rw, pcen, rd, m2r, sa, done, ill} = '0;
    sb = 2'b00; aop = 2'b00; pcs = 2'b00;
    if (!rn) sb = 2'b01;
    else begin
      case (st)
        0:  begin mreq = 1; sb = 2'b01; irw = mr; pcen = mr; end
        1:  begin sb = 2'b11; if (!(op inside {R, LW, SW, BEQ, ADDI, J})) begin done = 1; ill = 1; end end
        2:  begin sa = 1; sb = 2'b10; end
        3:  begin mreq = 1; iord = 1; end
        4:  begin rw = 1; m2r = 1; done = 1; end
        5:  begin mreq = 1; iord = 1; mw = 1; done = mr; end
        6:  begin sa = 1; aop = 2'b10; end
        7:  begin rw = 1; rd = 1; done = 1; end
        8:  begin sa = 1; aop = 2'b01; pcs = 2'b01; pcen = z; done = 1; end
        9:  begin sa = 1; sb = 2'b10; end
        10: begin rw = 1; done = 1; end
        11: begin pcs = 2'b10; pcen = 1; done = 1; end
        default: sb = 2'b01;
      endcase
    end
    return {mreq, iord, mw, irw, rw, pcen, rd, m2r, sa, sb, aop, pcs, done, ill};
  endfunction

  wire [16:0] act = {mem_req, IorD, MemWrite, IRWrite, RegWrite, PCEn, RegDst, MemtoReg, ALUSrcA,
                     ALUSrcB, ALUOp, PCSrc, instr_done, illegal_op};

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_state", 32'(state), 32'(mstate));
      chk("model_outputs", 32'(act), 32'(expv(mstate, mem_ready, zero, reset_n, opcode)));
    end
  end

  task automatic step(input logic rn, input logic mr, input logic z, input logic [5:0] op, input int exps);
    @(posedge clk);
    #1;
    reset_n = rn; mem_ready = mr; zero = z; opcode = op;
    @(negedge clk);
    chk("seq_state", 32'(state), 32'(exps));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; mem_ready = 1'b1; zero = 1'b0; opcode = R;
    repeat (3) begin
      step(0, 1, 0, R, 0);
      chk("reset_enables", 32'({MemWrite, IRWrite, RegWrite, PCEn, mem_req, instr_done, illegal_op}), 32'd0);
    end
    // R-type
    step(1, 1, 0, R, 0);
    chk("fetch_irwrite", 32'(IRWrite), 32'd1);
    chk("fetch_pcen", 32'(PCEn), 32'd1);
    step(1, 1, 0, R, 1);
    step(1, 1, 0, R, 6);
    chk("exec_aluop", 32'(ALUOp), 32'd2);
    chk("exec_srcb", 32'(ALUSrcB), 32'd0);
    step(1, 1, 0, R, 7);
    chk("aluwb_rw_rd_done", 32'({RegWrite, RegDst, instr_done}), 32'd7);
    // lw with two stall cycles in MEMRD
    step(1, 1, 0, LW, 0);
    step(1, 1, 0, LW, 1);
    step(1, 1, 0, LW, 2);
    step(1, 0, 0, LW, 3); chk("memrd_iord", 32'(IorD), 32'd1);
    step(1, 0, 0, LW, 3); chk("memrd_iord", 32'(IorD), 32'd1);
    step(1, 1, 0, LW, 3); chk("memrd_iord", 32'(IorD), 32'd1);
    step(1, 1, 0, LW, 4);
    chk("memwb_m2r_rw", 32'({MemtoReg, RegWrite}), 32'd3);
    // sw with one stall cycle in MEMWR
    step(1, 1, 0, SW, 0);
    step(1, 1, 0, SW, 1);
    step(1, 1, 0, SW, 2);
    step(1, 0, 0, SW, 5); chk("memwr_write_stall", 32'({MemWrite, RegWrite, instr_done}), 32'd4);
    step(1, 1, 0, SW, 5); chk("memwr_write_done", 32'({MemWrite, RegWrite, instr_done}), 32'd5);
    // beq taken, then not taken
    step(1, 1, 1, BEQ, 0); chk("after_sw_memwrite", 32'(MemWrite), 32'd0);
    step(1, 1, 1, BEQ, 1);
    step(1, 1, 1, BEQ, 8); chk("beq_taken", 32'({PCEn, PCSrc}), 32'd5);
    step(1, 1, 0, BEQ, 0);
    step(1, 1, 0, BEQ, 1);
    step(1, 1, 0, BEQ, 8); chk("beq_not_taken", 32'(PCEn), 32'd0);
    // jump
    step(1, 1, 0, J, 0);
    step(1, 1, 0, J, 1);
    step(1, 1, 0, J, 11); chk("jump_pcen_pcsrc", 32'({PCEn, PCSrc}), 32'd6);
    // illegal opcode
    step(1, 1, 0, ILL, 0);
    step(1, 1, 0, ILL, 1); chk("illegal_pulse", 32'({illegal_op, instr_done}), 32'd3);
    // store aborted by reset in MEMWR
    step(1, 1, 0, SW, 0);
    step(1, 1, 0, SW, 1);
    step(1, 1, 0, SW, 2);
    step(0, 1, 0, SW, 5); chk("reset_in_memwr", 32'(MemWrite), 32'd0);
    // addi
    step(1, 1, 0, ADDI, 0);
    step(1, 1, 0, ADDI, 1);
    step(1, 1, 0, ADDI, 9);
    step(1, 1, 0, ADDI, 10); chk("addiwb_rw_rd", 32'({RegWrite, RegDst, instr_done}), 32'd5);
    step(1, 1, 0, R, 0);

    // Randomized traffic; opcode only changes outside DECODE/MEMADR.
    repeat (3000) begin
      @(posedge clk);
      #1;
      reset_n   = ($urandom_range(0, 99) != 0);
      mem_ready = ($urandom_range(0, 3) != 0);
      zero      = 1'($urandom_range(0, 1));
      if (mstate != 1 && mstate != 2) begin
        case ($urandom_range(0, 7))
          0: opcode = R;
          1: opcode = LW;
          2: opcode = SW;
          3: opcode = BEQ;
          4: opcode = ADDI;
          5: opcode = J;
          default: opcode = 6'($urandom_range(0, 63));
        endcase
      end
    end
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Main control FSM for the multicycle MIPS datapath. It sequences fetch, decode, execute, memory and writeback over successive cycles, and drives the shared ALU's operand selects and the 2-bit `ALUOp` consumed by the ALU decoder. It stalls on a simple memory ready handshake and produces the PC enable from `Branch`/`zero`. It sits between the instruction register opcode field and the datapath's mux selects and write enables.

## Interface
- No parameters. Opcode and state encodings are fixed below.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `opcode` in 6: `instr[31:26]` from the instruction register.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory has completed the current read or write this cycle.
- `mem_req` out 1: memory access requested.
- `IorD` out 1: memory address select (0 = PC, 1 = ALUOut).
- `MemWrite`, `IRWrite`, `RegWrite`, `PCEn` out 1 each: write enables.
- `RegDst`, `MemtoReg`, `ALUSrcA` out 1 each: datapath mux selects.
- `ALUSrcB` out 2: 00 = B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2.
- `ALUOp` out 2: 00 = add, 01 = subtract, 10 = decode funct.
- `PCSrc` out 2: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- `state` out 4: current state, for debug.
- `instr_done` out 1: one-cycle pulse in the final state of each instruction.
- `illegal_op` out 1: one-cycle pulse when DECODE sees an unsupported opcode.

## Operation
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- Outputs are Moore, decoded from `state`. Exceptions: write enables in FETCH and MEMWR, and `PCEn` in BEQ.
- Every output not listed for a state is 0.
- `PCEn` = `PCWrite` | (`Branch` & `zero`). `PCWrite` and `Branch` are internal signals.

State encodings, outputs and transitions:
- FETCH = 0: `mem_req`=1, `IorD`=0, `ALUSrcA`=0, `ALUSrcB`=01, `ALUOp`=00, `PCSrc`=00.
  - `IRWrite` and `PCWrite` equal `mem_ready`.
  - Moves to DECODE when `mem_ready`=1, otherwise holds.
- DECODE = 1: `ALUSrcA`=0, `ALUSrcB`=11, `ALUOp`=00 (branch target into ALUOut).
  - lw/sw → MEMADR; R-type → EXECUTE; beq → BEQ; addi → ADDIEX; j → JUMP.
  - Any other opcode → FETCH with `illegal_op`=1 and `instr_done`=1.
- MEMADR = 2: `ALUSrcA`=1, `ALUSrcB`=10, `ALUOp`=00. lw → MEMRD; sw → MEMWR.
- MEMRD = 3: `mem_req`=1, `IorD`=1. Moves to MEMWB on `mem_ready`, otherwise holds.
- MEMWB = 4: `RegWrite`=1, `MemtoReg`=1, `RegDst`=0, `instr_done`=1. → FETCH.
- MEMWR = 5: `mem_req`=1, `IorD`=1, `MemWrite`=1 held until `mem_ready`.
  - On `mem_ready`: `instr_done`=1, → FETCH.
- EXECUTE = 6: `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=10. → ALUWB.
- ALUWB = 7: `RegWrite`=1, `RegDst`=1, `MemtoReg`=0, `instr_done`=1. → FETCH.
- BEQ = 8: `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=01, `Branch`=1, `PCSrc`=01, `instr_done`=1. → FETCH.
- ADDIEX = 9: `ALUSrcA`=1, `ALUSrcB`=10, `ALUOp`=00. → ADDIWB.
- ADDIWB = 10: `RegWrite`=1, `RegDst`=0, `MemtoReg`=0, `instr_done`=1. → FETCH.
- JUMP = 11: `PCSrc`=10, `PCWrite`=1, `instr_done`=1. → FETCH.
- Encodings 12–15 are unreachable. If entered, outputs are as FETCH with all enables 0, and the next state is FETCH.
- `opcode` is sampled only in DECODE and MEMADR. The IR is stable there because `IRWrite` is 0 outside FETCH.

## Timing
- Reset: when `reset_n`=0 at a rising edge, `state` becomes FETCH.
- While `reset_n`=0, `MemWrite`, `IRWrite`, `RegWrite`, `PCEn`, `mem_req`, `instr_done` and `illegal_op` are forced to 0. All other outputs follow FETCH.
- Reset asserted mid-instruction abandons the instruction. No write enable is asserted in the reset cycle.
- Cycles per instruction with `mem_ready` tied to 1:
  - R-type 4, lw 5, sw 4, beq 3, addi 4, j 3, illegal 2.
- Each cycle with `mem_ready`=0 in FETCH, MEMRD or MEMWR adds exactly one cycle.
- During such a stall, all outputs hold their values and no write enable other than `MemWrite` (in MEMWR) is asserted.
- `instr_done` is high for exactly one cycle per instruction, in the cycle before returning to FETCH.

## Test plan
- Reset: hold `reset_n`=0 for 3 cycles with `mem_ready`=1 → `state`=0 and all enables 0 throughout. First FETCH cycle after release has `IRWrite`=`PCEn`=1.
- R-type, `mem_ready`=1: states 0,1,6,7,0. In state 6, `ALUOp`=10 and `ALUSrcB`=00. In state 7, `RegWrite`=`RegDst`=1 and `instr_done`=1.
- lw with `mem_ready` low for 2 cycles in MEMRD: states 0,1,2,3,3,3,4,0. `IorD`=1 in all state-3 cycles, and `MemtoReg`=`RegWrite`=1 in state 4.
- sw with `mem_ready` low for 1 cycle in MEMWR: `MemWrite`=1 for 2 consecutive cycles, then state returns to 0 and `RegWrite` is never asserted.
- beq: `zero`=1 gives `PCEn`=1 and `PCSrc`=01 in state 8. `zero`=0 gives `PCEn`=0. j: `PCEn`=1 and `PCSrc`=10 in state 11.
- Illegal opcode 111111: DECODE pulses `illegal_op`=`instr_done`=1 and the next state is 0. Separately, asserting reset in MEMWR aborts the store (`MemWrite`=0 in that cycle) and the next state is 0.
